// File: rtl/ofdm_subcarrier_mapper.sv
// OFDM subcarrier mapper: packs modulated data symbols, BPSK pilots
// and null bins into natural-order IFFT frames over valid/ready.
module ofdm_subcarrier_mapper #(
  parameter int fft_depth     = 12,
  parameter int FFT_SIZE      = 64,
  parameter int HALF_USED     = 26,
  parameter int PILOT_SPACING = 8,
  parameter int PILOT_OFFSET  = 4,
  parameter int PILOT_LEVEL   = 1200,
  localparam int KW = $clog2(FFT_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [fft_depth-1:0] in_i,
  input  logic [fft_depth-1:0] in_q,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [fft_depth-1:0] out_i,
  output logic [fft_depth-1:0] out_q,
  output logic [KW-1:0]        out_index,
  output logic                 out_sof,
  output logic                 out_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [15:0]          frame_cnt
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [KW-1:0] KMAX = KW'(FFT_SIZE - 1);
  localparam logic [KW-1:0] NLO  = KW'(HALF_USED);
  localparam logic [KW-1:0] NHI  = KW'(FFT_SIZE - HALF_USED);
  localparam logic [KW-1:0] PMSK = KW'(PILOT_SPACING - 1);
  localparam logic [KW-1:0] POFF = KW'(PILOT_OFFSET);
  localparam logic [fft_depth-1:0] PPOS = fft_depth'(PILOT_LEVEL);
  localparam logic [fft_depth-1:0] PNEG = fft_depth'(-PILOT_LEVEL);

  state_t               state_q, state_d;
  logic [KW-1:0]        k_q, k_d;
  logic [6:0]           lfsr_q, lfsr_d;
  logic [15:0]          cnt_d;
  logic                 ov_d, sof_d, last_d;
  logic [fft_depth-1:0] oi_d, oq_d;
  logic [KW-1:0]        idx_d;
  logic                 load_en, is_null, is_pilot, fb, beat;

  assign load_en  = !out_valid || out_ready;
  assign is_null  = (k_q == '0) || (k_q > NLO && k_q < NHI);
  assign is_pilot = !is_null && ((k_q & PMSK) == POFF);
  assign fb       = lfsr_q[6] ^ lfsr_q[3];

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    lfsr_d   = lfsr_q;
    cnt_d    = frame_cnt;
    ov_d     = out_valid;
    oi_d     = out_i;
    oq_d     = out_q;
    idx_d    = out_index;
    sof_d    = out_sof;
    last_d   = out_last;
    in_ready = 1'b0;
    beat     = 1'b0;
    unique case (state_q)
      IDLE: begin
        k_d = '0;
        if (load_en) ov_d = 1'b0;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (load_en) begin
          unique case (1'b1)
            is_null: begin
              beat = 1'b1;
              oi_d = '0;
              oq_d = '0;
            end
            is_pilot: begin
              beat = 1'b1;
              oi_d = fb ? PNEG : PPOS;
              oq_d = '0;
            end
            default: begin
              in_ready = 1'b1;
              if (in_valid) begin
                beat = 1'b1;
                oi_d = in_i;
                oq_d = in_q;
              end else begin
                ov_d = 1'b0;
              end
            end
          endcase
          if (beat) begin
            ov_d   = 1'b1;
            idx_d  = k_q;
            sof_d  = (k_q == '0);
            last_d = (k_q == KMAX);
            if (k_q == KMAX) begin
              // frame done: new pilot polarity for the next frame
              k_d     = '0;
              state_d = IDLE;
              lfsr_d  = {lfsr_q[5:0], fb};
              cnt_d   = frame_cnt + 16'd1;
            end else begin
              k_d = k_q + 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      k_q       <= '0;
      lfsr_q    <= 7'h7F;
      frame_cnt <= '0;
      out_valid <= 1'b0;
      out_i     <= '0;
      out_q     <= '0;
      out_index <= '0;
      out_sof   <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      lfsr_q    <= lfsr_d;
      frame_cnt <= cnt_d;
      out_valid <= ov_d;
      out_i     <= oi_d;
      out_q     <= oq_d;
      out_index <= idx_d;
      out_sof   <= sof_d;
      out_last  <= last_d;
    end
  end

endmodule

// File: doc/ofdm_subcarrier_mapper.md
Name: ofdm_subcarrier_mapper

Overview:
- Sits directly downstream of the per-subcarrier modulators (qpsk_mod and siblings). Consumes one mapped I/Q data symbol per handshake and emits a full FFT_SIZE-bin frame in natural IFFT input order.
- Inserts DC null, guard-band zeros and BPSK pilots with per-frame scrambled polarity.
- Output feeds the IFFT input stage through a registered valid/ready interface.

Parameters:
- fft_depth, 12, I/Q sample width (two's complement); matches modulator output width.
- FFT_SIZE, 64, bins per frame; power of two.
- HALF_USED, 26, used bins each side of DC: positive bins 1..HALF_USED, negative bins FFT_SIZE-HALF_USED..FFT_SIZE-1.
- PILOT_SPACING, 8, pilot period in bin index; power of two.
- PILOT_OFFSET, 4, pilot when (k mod PILOT_SPACING)==PILOT_OFFSET and bin k is used.
- PILOT_LEVEL, 1200, pilot magnitude on I; must fit signed fft_depth.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- in_i, in, fft_depth, data symbol I (sub_i from modulator).
- in_q, in, fft_depth, data symbol Q (sub_q from modulator).
- in_valid, in, 1, input symbol valid.
- in_ready, out, 1, input symbol accepted when in_valid && in_ready.
- out_i, out, fft_depth, bin I value.
- out_q, out, fft_depth, bin Q value.
- out_index, out, log2(FFT_SIZE), bin index k of current beat.
- out_sof, out, 1, high on the k=0 beat.
- out_last, out, 1, high on the k=FFT_SIZE-1 beat.
- out_valid, out, 1, output beat valid.
- out_ready, in, 1, downstream accepts beat when out_valid && out_ready.
- frame_cnt, out, 16, completed frames; wraps at 2^16.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid, out_i, out_q, out_index, out_sof, out_last, in_ready, frame_cnt are 0.
  - state=IDLE, k=0, LFSR=7'h7F.
  - Reset mid-frame abandons the partial frame. No partial beats after release.
- Bin classes for index k:
  - NULL: k==0, or HALF_USED<k<FFT_SIZE-HALF_USED. Emits (0,0).
  - PILOT: used bin with k mod PILOT_SPACING == PILOT_OFFSET. Emits (±PILOT_LEVEL, 0).
  - DATA: all other used bins. Emits the accepted input symbol unchanged.
  - Defaults give 6 pilots (4,12,20,44,52,60) and 46 data bins per frame.
- Output register rule: the register loads when load_en = !out_valid || out_ready.
- State IDLE: k=0, in_ready=0. On in_valid=1, go to RUN next cycle. No beat is emitted in that cycle.
- State RUN, per cycle with load_en:
  - NULL or PILOT bin: load the beat, k++.
  - DATA bin: in_ready = load_en. If in_valid, load in_i/in_q and k++. Otherwise out_valid drops to 0 on this load (underflow stall), and k holds.
  - in_ready is combinational, high only in RUN on a DATA bin with load_en.
- One cycle of latency from accept to out_valid.
- out_index, out_sof and out_last are registered with the beat.
- End of frame: when the k=FFT_SIZE-1 beat is loaded:
  - k wraps to 0 and the state returns to IDLE.
  - LFSR advances and frame_cnt++ (in the same cycle).
  - One bubble cycle minimum between frames.
- Pilot polarity: fb = lfsr[6]^lfsr[3]; pilot I = fb ? -PILOT_LEVEL : +PILOT_LEVEL. Constant for the whole frame. Advance rule: lfsr <= {lfsr[5:0],fb}. Resulting sequence from seed: frames 0–3 positive, frame 4 negative.
- Back-pressure (out_ready=0 with out_valid=1): all outputs hold stable, k holds, in_ready=0.
- -PILOT_LEVEL is computed in fft_depth-bit two's complement (1200 -> 12'hB50).

Test Plan:
- Reset, then in_valid held high with data (i=1200,q=-1200) and out_ready=1 -> exactly 64 beats k=0..63; out_sof on k=0, out_last on k=63. Bins 0 and 27..37 are (0,0). Pilots 4,12,20,44,52,60 carry (1200,0). 46 input accepts. frame_cnt=1.
- Five consecutive frames -> pilot I is +1200 for frames 0–3 and 12'hB50 (-1200) for frame 4. frame_cnt=5.
- in_valid dropped at bin 2 for 3 cycles -> out_valid=0 for those cycles, no index skipped, bin 2 carries the late symbol, bins 0–1 unaffected.
- out_ready toggled randomly (50%) -> no beat lost or duplicated, outputs stable while stalled, accepted data order equals input order.
- rst_n asserted mid-frame at k=30 -> outputs 0 immediately. After release and in_valid, a new frame starts at k=0 with positive pilots and frame_cnt=0.
- in_valid=0 after reset -> module stays IDLE, out_valid=0, in_ready=0 indefinitely.
